// File: rtl/cam_pixel_capture.sv
// Camera RGB444 byte-pair stream to 12-bit frame-buffer writes, in the pixel-clock domain.
// WriteEn rises one clock after the second byte of a pixel reaches data_q; no backpressure.
module cam_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cam_vsynk,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] WriteAdd,
  output logic [11:0]       WriteData,
  output logic              frame_done,
  output logic              line_err,
  output logic [7:0]        frame_count
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [PW-1:0]     H_MAX  = PW'(H_ACTIVE);
  localparam logic [LW-1:0]     V_MAX  = LW'(V_ACTIVE);
  localparam logic [LW-1:0]     V_LAST = LW'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state, state_nxt;

  logic              vs_q, href_q, vs_d, href_d;
  logic [7:0]        data_q;
  logic              phase, ovf, we_r;
  logic [3:0]        r_lat;
  logic [PW-1:0]     pixel;
  logic [LW-1:0]     line;
  logic [ADDR_W-1:0] line_base;

  logic          vs_rise, vs_fall, href_rise, href_fall;
  logic          byte_vld, close_line, pix_ok, ovf_cur;
  logic [PW-1:0] pix_cur;

  assign vs_rise   = vs_q & ~vs_d;
  assign vs_fall   = ~vs_q & vs_d;
  assign href_rise = href_q & ~href_d;
  assign href_fall = ~href_q & href_d;

  // A line still open when vsync rises is closed exactly like an href fall.
  assign byte_vld   = (state == CAPTURE) && href_q && !vs_rise;
  assign close_line = (state == CAPTURE) && (href_fall || (vs_rise && href_q));
  assign pix_cur    = href_rise ? '0 : pixel;
  assign ovf_cur    = href_rise ? 1'b0 : ovf;
  assign pix_ok     = (pix_cur < H_MAX) && (line < V_MAX);

  // Reset gates the strobe combinationally so a write never escapes the reset cycle.
  assign WriteEn = we_r & ~reset;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && vs_q) state_nxt = ARMED;
      ARMED:   if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: if (vs_rise) state_nxt = enable ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q        <= 1'b0;
      href_q      <= 1'b0;
      vs_d        <= 1'b0;
      href_d      <= 1'b0;
      data_q      <= '0;
      phase       <= 1'b0;
      ovf         <= 1'b0;
      r_lat       <= '0;
      pixel       <= '0;
      line        <= '0;
      line_base   <= '0;
      we_r        <= 1'b0;
      WriteAdd    <= '0;
      WriteData   <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_q       <= cam_vsynk;
      href_q     <= cam_href;
      data_q     <= cam_data;
      vs_d       <= vs_q;
      href_d     <= href_q;
      we_r       <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;

      if (state == ARMED && vs_fall) begin
        line      <= '0;
        line_base <= '0;
        pixel     <= '0;
        phase     <= 1'b0;
        ovf       <= 1'b0;
      end

      if (byte_vld) begin
        phase <= ~phase;
        ovf   <= ovf_cur;
        pixel <= pix_cur;
        if (!phase) begin
          r_lat <= data_q[3:0];
        end else begin
          if (pix_ok) begin
            we_r      <= 1'b1;
            WriteAdd  <= line_base + ADDR_W'(pix_cur);
            WriteData <= {r_lat, data_q};
          end
          // Pixels past the end of the line are only remembered as an overflow.
          if (pix_cur != H_MAX) pixel <= pix_cur + 1'b1;
          else                  ovf   <= 1'b1;
        end
      end

      if (close_line) begin
        line_err <= phase || ovf || (pixel != H_MAX);
        phase    <= 1'b0;
        if (pixel != '0) begin
          if (line != V_MAX)  line      <= line + 1'b1;
          if (line < V_LAST)  line_base <= line_base + H_ADDR;
        end
      end

      if (state == CAPTURE && vs_rise) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Random camera frames against a line-level reference model of the pixel capture block.
module tb_cam_pixel_capture;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset, enable, cam_vsynk, cam_href;
  logic [7:0]    cam_data;
  logic          WriteEn, frame_done, line_err;
  logic [AW-1:0] WriteAdd;
  logic [11:0]   WriteData;
  logic [7:0]    frame_count;

  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cam_vsynk(cam_vsynk),
    .cam_href(cam_href), .cam_data(cam_data), .WriteEn(WriteEn),
    .WriteAdd(WriteAdd), .WriteData(WriteData), .frame_done(frame_done),
    .line_err(line_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int got_add[$], got_dat[$], exp_add[$], exp_dat[$];
  int err_cnt = 0, fd_cnt = 0, exp_err = 0, exp_fd = 0, exp_fc = 0;
  int m_line = 0;
  int lat_cyc = 0;
  bit lat_armed = 0, want_lat = 0;
  int lens[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WriteEn) begin
      got_add.push_back(int'(WriteAdd));
      got_dat.push_back(int'(WriteData));
      if (lat_armed) begin
        chk("latency", 32'(cyc - lat_cyc), 32'd2);
        chk("lat_data", 32'(WriteData), 32'h0A5C);
        lat_armed = 0;
      end
    end
    if (line_err)   err_cnt++;
    if (frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_line(input int len, input bit cap);
    logic [7:0] b[$];
    logic [7:0] v, b0, b1;
    bit lat = want_lat;
    int npix;
    for (int i = 0; i < len; i++) begin
      v = 8'($urandom_range(0, 255));
      if (lat && i == 0) v = 8'h0A;
      if (lat && i == 1) v = 8'h5C;
      b.push_back(v);
    end
    want_lat = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      cam_href = 1'b1;
      cam_data = b[i];
      if (lat && i == 1) begin
        lat_cyc   = cyc;
        lat_armed = 1;
      end
    end
    @(posedge clk); #1;
    cam_href = 1'b0;
    cam_data = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    if (cap) begin
      npix = len / 2;
      for (int p = 0; p < npix; p++) begin
        b0 = b[2*p];
        b1 = b[2*p+1];
        if (p < H && m_line < V) begin
          exp_add.push_back(m_line * H + p);
          exp_dat.push_back(int'({b0[3:0], b1}));
        end
      end
      if ((len % 2) != 0 || npix != H) exp_err++;
      if (npix > 0 && m_line < V) m_line++;
    end
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    cam_vsynk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cam_vsynk = 1'b0;
    m_line = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame_end(input bit cap);
    @(posedge clk); #1;
    cam_vsynk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (cap) begin
      exp_fd++;
      exp_fc = (exp_fc + 1) % 256;
    end
  endtask

  task automatic clear_model();
    got_add.delete(); got_dat.delete(); exp_add.delete(); exp_dat.delete();
    err_cnt = 0; fd_cnt = 0; exp_err = 0; exp_fd = 0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nwr"}, 32'(got_add.size()), 32'(exp_add.size()));
    for (int i = 0; i < got_add.size() && i < exp_add.size(); i++) begin
      chk($sformatf("%s_add%0d", tag, i), 32'(got_add[i]), 32'(exp_add[i]));
      chk($sformatf("%s_dat%0d", tag, i), 32'(got_dat[i]), 32'(exp_dat[i]));
    end
    chk({tag, "_line_err"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_frame_done"}, 32'(fd_cnt), 32'(exp_fd));
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
    clear_model();
  endtask

  initial begin
    bit hit;
    lens = '{2*H, 2*H+1, 2*H-2, 2*H+12, 1, 3};
    reset = 1'b1; enable = 1'b0; cam_vsynk = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(WriteEn), 0);
    chk("rst_add", 32'(WriteAdd), 0);
    chk("rst_dat", 32'(WriteData), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_le", 32'(line_err), 0);
    chk("rst_fc", 32'(frame_count), 0);
    reset = 1'b0;
    enable = 1'b1;

    // Clean frame; first pixel carries the 0x0A,0x5C latency probe.
    want_lat = 1;
    frame_start();
    for (int l = 0; l < V; l++) send_line(2*H, 1);
    frame_end(1);
    check_frame("full");
    chk("lat_consumed", 32'(lat_armed), 0);

    // Odd-length, overlong, short lines.
    frame_start();
    send_line(2*H+1, 1);
    send_line(2*H+12, 1);
    send_line(2*H, 1);
    for (int l = 0; l < 3; l++) send_line(lens[$urandom_range(0, 5)], 1);
    frame_end(1);
    check_frame("odd");

    // More lines than V_ACTIVE: extra lines are dropped without wrapping.
    frame_start();
    for (int l = 0; l < V + 2; l++) send_line(lens[$urandom_range(0, 3)], 1);
    frame_end(1);
    check_frame("tall");

    frame_start();
    send_line(2*H, 1);
    send_line(2*H, 1);
    frame_end(1);
    check_frame("short");

    // Enable dropped mid-frame: this frame completes, the next is ignored.
    frame_start();
    enable = 1'b0;
    for (int l = 0; l < 3; l++) send_line(2*H, 1);
    frame_end(1);
    check_frame("en_drop");
    frame_start();
    for (int l = 0; l < 2; l++) send_line(2*H, 0);
    frame_end(0);
    check_frame("disabled");

    // Reset in the middle of a line.
    enable = 1'b1;
    frame_start();
    send_line(2*H, 1);
    send_line(2*H, 1);
    hit = 0;
    for (int i = 0; i < 2*H; i++) begin
      @(posedge clk); #1;
      if (WriteEn && i >= 4) begin
        hit = 1;
        break;
      end
      cam_href = 1'b1;
      cam_data = 8'($urandom_range(0, 255));
    end
    chk("rst_mid_write_seen", 32'(hit), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", 32'(WriteEn), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cam_href = 1'b0;
    chk("rst_mid_fc", 32'(frame_count), 0);
    chk("rst_mid_add", 32'(WriteAdd), 0);
    exp_fc = 0;
    clear_model();
    send_line(2*H, 0);
    send_line(2*H, 0);
    frame_end(0);
    check_frame("rst_rest");

    frame_start();
    for (int l = 0; l < V; l++) send_line(lens[$urandom_range(0, 2)], 1);
    frame_end(1);
    check_frame("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
